microsequencer: RTL and testbench

Parametrised microprogram sequencer for the ARM datapath control path. It is the next generation of the fixed 6-bit control unit: microaddress width, microword width, condition count and microstack depth are all configurable. It adds conditional branch, subroutine call/return, wait-for-condition and pipeline hold. It drives an external asynchronous-read microcode ROM and presents the registered control field of the current microinstruction to the datapath.

---
 rtl/microsequencer.sv | 135 +++++++++++++
 tb/tb_microsequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
`timescale 1ns/1ps
// Microprogram sequencer: registered microinstruction (MIR) and microPC, a return-address
// stack, and the combinational next-address path that drives an async-read microcode ROM.
module microsequencer #(
  parameter  int AW     = 7,
  parameter  int CW     = 48,
  parameter  int NCOND  = 4,
  parameter  int SDEPTH = 4,
  localparam int CS     = (NCOND > 1) ? $clog2(NCOND) : 1,
  localparam int DW     = $clog2(SDEPTH + 1),
  localparam int CTW    = CW - AW - CS - 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             hold,
  input  logic [NCOND-1:0] cond_in,
  input  logic [AW-1:0]    dec_addr,
  output logic [AW-1:0]    rom_addr,
  input  logic [CW-1:0]    rom_data,
  output logic [CTW-1:0]   ctrl,
  output logic [AW-1:0]    upc,
  output logic [DW-1:0]    depth,
  output logic             stk_ovf,
  output logic             stk_unf
);

  localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  typedef enum logic [2:0] {
    NS_JUMP, NS_INC, NS_DECODE, NS_CJUMP, NS_CDEC, NS_CALL, NS_RET, NS_WAIT
  } ns_e;

  logic [CW-1:0]   mir_q;
  logic [AW-1:0]   upc_q, upc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0]   stack_q [SDEPTH];

  ns_e             ns;
  logic [CS-1:0]   csel;
  logic            inv;
  logic [AW-1:0]   target;
  logic [2**CS-1:0] cond_pad;
  logic            cond;
  logic [AW-1:0]   upc_inc;
  logic [AW-1:0]   stack_top;
  logic            push, pop, full, empty;

  assign ns     = ns_e'(mir_q[CW-1 -: 3]);
  assign csel   = mir_q[CW-4 -: CS];
  assign inv    = mir_q[CW-4-CS];
  assign target = mir_q[CW-5-CS -: AW];

  // Selector codes beyond the implemented inputs read as a constant 0.
  for (genvar gi = 0; gi < 2**CS; gi++) begin : g_cond
    if (gi < NCOND) begin : g_src
      assign cond_pad[gi] = cond_in[gi];
    end else begin : g_zero
      assign cond_pad[gi] = 1'b0;
    end
  end

  assign cond      = cond_pad[csel] ^ inv;
  assign upc_inc   = upc_q + AW'(1);
  assign full      = (depth_q == DW'(SDEPTH));
  assign empty     = (depth_q == '0);
  assign stack_top = stack_q[IW'(depth_q - DW'(1))];

  always_comb begin
    upc_d   = upc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (ns)
      NS_JUMP:   upc_d = target;
      NS_INC:    upc_d = upc_inc;
      NS_DECODE: upc_d = dec_addr;
      NS_CJUMP:  upc_d = cond ? target : upc_inc;
      NS_CDEC:   upc_d = cond ? dec_addr : upc_inc;
      NS_CALL: begin
        upc_d = target;
        push  = 1'b1;
      end
      NS_RET: begin
        upc_d = empty ? '0 : stack_top;
        pop   = 1'b1;
      end
      NS_WAIT:   upc_d = cond ? upc_inc : upc_q;
      default:   upc_d = upc_inc;
    endcase
    // A full push keeps the jump but drops the return address; an empty pop returns to 0.
    if (push) begin
      if (full) ovf_d = 1'b1;
      else      depth_d = depth_q + DW'(1);
    end
    if (pop) begin
      if (empty) unf_d = 1'b1;
      else       depth_d = depth_q - DW'(1);
    end
  end

  assign rom_addr = upc_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      upc_q   <= '0;
      mir_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!hold) begin
      upc_q   <= upc_d;
      mir_q   <= rom_data;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack entries carry no reset; depth alone defines which are valid.
  always_ff @(posedge clk) begin
    if (!hold && push && !full) begin
      stack_q[IW'(depth_q)] <= upc_inc;
    end
  end

  assign ctrl    = mir_q[CTW-1:0];
  assign upc     = upc_q;
  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

endmodule

// File: tb/tb_microsequencer.sv
`timescale 1ns/1ps
// Directed bench: walks a hand-built microprogram through wrap, wait, branch, nesting,
// overflow/underflow, hold and mid-subroutine reset, checking upc/ctrl/depth each cycle.
module tb_microsequencer;

  localparam int AW = 7, CW = 48, NCOND = 3, SDEPTH = 4;
  localparam int CTW = 35;

  logic             clk = 1'b0;
  logic             clr;
  logic             hold;
  logic [NCOND-1:0] cond_in;
  logic [AW-1:0]    dec_addr;
  logic [AW-1:0]    rom_addr;
  logic [CW-1:0]    rom_data;
  logic [CTW-1:0]   ctrl;
  logic [AW-1:0]    upc;
  logic [2:0]       depth;
  logic             stk_ovf, stk_unf;

  logic [CW-1:0]    rom [128];
  int               checks = 0;
  int               errors = 0;

  microsequencer #(.AW(AW), .CW(CW), .NCOND(NCOND), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .clr(clr), .hold(hold), .cond_in(cond_in), .dec_addr(dec_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .ctrl(ctrl), .upc(upc), .depth(depth),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  function automatic logic [CTW-1:0] ctrl_of(input logic [6:0] a);
    return {a, (28'(a) * 28'd7) ^ 28'h5A5A5A5};
  endfunction

  function automatic logic [CW-1:0] mk(input logic [2:0] ns, input logic [1:0] csel,
                                        input logic inv, input logic [6:0] tgt,
                                        input logic [6:0] a);
    return {ns, csel, inv, tgt, ctrl_of(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] eu, input logic [2:0] ed);
    @(posedge clk);
    #1;
    $display("step %-8s upc=%02h depth=%0d ovf=%0b unf=%0b rom_addr=%02h",
             tag, upc, depth, stk_ovf, stk_unf, rom_addr);
    check({tag, ".upc"},   64'(upc),   64'(eu));
    check({tag, ".ctrl"},  64'(ctrl),  64'(ctrl_of(eu)));
    check({tag, ".depth"}, 64'(depth), 64'(ed));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = mk(3'd0, 2'd0, 1'b0, 7'd0, 7'(i));
    rom[0]     = mk(3'd3, 2'd2, 1'b1, 7'd125, 7'd0);
    rom[125]   = mk(3'd1, 2'd0, 1'b0, 7'd0, 7'd125);
    rom[126]   = mk(3'd1, 2'd0, 1'b0, 7'd0, 7'd126);
    rom[127]   = mk(3'd1, 2'd0, 1'b0, 7'd0, 7'd127);
    rom[1]     = mk(3'd2, 2'd0, 1'b0, 7'd0, 7'd1);
    rom[5]     = mk(3'd7, 2'd0, 1'b0, 7'd0, 7'd5);
    rom[6]     = mk(3'd7, 2'd0, 1'b1, 7'd0, 7'd6);
    rom[7]     = mk(3'd3, 2'd1, 1'b0, 7'h10, 7'd7);
    rom[7'h10] = mk(3'd3, 2'd1, 1'b0, 7'h18, 7'h10);
    rom[7'h11] = mk(3'd4, 2'd1, 1'b1, 7'd0, 7'h11);
    rom[7'h2A] = mk(3'd3, 2'd3, 1'b0, 7'h70, 7'h2A);
    rom[7'h2B] = mk(3'd4, 2'd3, 1'b0, 7'd0, 7'h2B);
    rom[7'h2C] = mk(3'd5, 2'd0, 1'b0, 7'h20, 7'h2C);
    rom[7'h20] = mk(3'd5, 2'd0, 1'b0, 7'h30, 7'h20);
    rom[7'h30] = mk(3'd5, 2'd0, 1'b0, 7'h40, 7'h30);
    rom[7'h40] = mk(3'd5, 2'd0, 1'b0, 7'h50, 7'h40);
    rom[7'h50] = mk(3'd5, 2'd0, 1'b0, 7'h60, 7'h50);
    rom[7'h60] = mk(3'd6, 2'd0, 1'b0, 7'd0, 7'h60);
    rom[7'h41] = mk(3'd6, 2'd0, 1'b0, 7'd0, 7'h41);
    rom[7'h31] = mk(3'd6, 2'd0, 1'b0, 7'd0, 7'h31);
    rom[7'h21] = mk(3'd6, 2'd0, 1'b0, 7'd0, 7'h21);
    rom[7'h2D] = mk(3'd6, 2'd0, 1'b0, 7'd0, 7'h2D);
    rom[7'h48] = mk(3'd5, 2'd0, 1'b0, 7'h58, 7'h48);
    rom[7'h58] = mk(3'd5, 2'd0, 1'b0, 7'h68, 7'h58);
    rom[7'h68] = mk(3'd7, 2'd0, 1'b0, 7'd0, 7'h68);

    clr = 1'b0; hold = 1'b0; cond_in = 3'b000; dec_addr = 7'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ctrl",     64'(ctrl),     64'd0);
    check("rst.upc",      64'(upc),      64'd0);
    check("rst.rom_addr", 64'(rom_addr), 64'd0);
    check("rst.depth",    64'(depth),    64'd0);
    check("rst.flags",    64'({stk_ovf, stk_unf}), 64'd0);
    clr = 1'b1;

    step("first", 7'd0, 3'd0);
    check("first.rom_addr", 64'(rom_addr), 64'd125);
    step("inc125", 7'd125, 3'd0);
    step("inc126", 7'd126, 3'd0);
    step("inc127", 7'd127, 3'd0);
    cond_in[2] = 1'b1;
    step("wrap0", 7'd0, 3'd0);
    step("dec1", 7'd1, 3'd0);
    for (int i = 0; i < 4; i++) step("wait5", 7'd5, 3'd0);
    cond_in[0] = 1'b1;
    step("wait6", 7'd6, 3'd0);
    step("winv6", 7'd6, 3'd0);
    cond_in[0] = 1'b0;
    step("winv7", 7'd7, 3'd0);
    cond_in[1] = 1'b1;
    step("cjmpT", 7'h10, 3'd0);
    cond_in[1] = 1'b0; dec_addr = 7'h2A;
    step("cjmpF", 7'h11, 3'd0);
    step("cdecT", 7'h2A, 3'd0);
    step("cselhi", 7'h2B, 3'd0);
    step("cdechi", 7'h2C, 3'd0);
    step("call1", 7'h20, 3'd1);
    step("call2", 7'h30, 3'd2);
    step("call3", 7'h40, 3'd3);
    step("call4", 7'h50, 3'd4);
    check("call4.ovf", 64'(stk_ovf), 64'd0);
    step("call5", 7'h60, 3'd4);
    check("call5.ovf", 64'(stk_ovf), 64'd1);
    check("call5.unf", 64'(stk_unf), 64'd0);
    step("ret1", 7'h41, 3'd3);
    step("ret2", 7'h31, 3'd2);
    step("ret3", 7'h21, 3'd1);
    step("ret4", 7'h2D, 3'd0);
    dec_addr = 7'h48;
    step("ret5", 7'd0, 3'd0);
    check("ret5.unf", 64'(stk_unf), 64'd1);
    check("ret5.ovf", 64'(stk_ovf), 64'd1);
    step("re1", 7'd1, 3'd0);
    step("enter48", 7'h48, 3'd0);
    hold = 1'b1;
    #1;
    check("hold.rom_addr", 64'(rom_addr), 64'h58);
    for (int i = 0; i < 3; i++) begin
      step("hold", 7'h48, 3'd0);
      check("hold.rom_addr", 64'(rom_addr), 64'h58);
    end
    hold = 1'b0;
    step("callA", 7'h58, 3'd1);
    step("callB", 7'h68, 3'd2);
    step("waitB", 7'h68, 3'd2);
    clr = 1'b0;
    #1;
    check("clr.upc",      64'(upc),      64'd0);
    check("clr.ctrl",     64'(ctrl),     64'd0);
    check("clr.depth",    64'(depth),    64'd0);
    check("clr.flags",    64'({stk_ovf, stk_unf}), 64'd0);
    check("clr.rom_addr", 64'(rom_addr), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    step("restart", 7'd0, 3'd0);
    check("restart.flags", 64'({stk_ovf, stk_unf}), 64'd0);
    step("restart1", 7'd1, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
